// File: rtl/bsram_arbiter.sv
// Arbitrates boot/CPU writes and CPU/LCD reads onto a semi-dual-port BSRAM.
// Optional `define BSRAM_ARB_LCD_PRIO_EN: LCD reads get fixed priority over CPU reads.
module bsram_arbiter #(
   parameter int unsigned ADDR_W       = 13,
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned READ_LATENCY = 2
) (
   input  logic              MEMORY_CLK,
   input  logic              rst,
   input  logic              boot_wr_req,
   input  logic [ADDR_W-1:0] boot_wr_addr,
   input  logic [DATA_W-1:0] boot_wr_data,
   output logic              boot_wr_gnt,
   input  logic              cpu_wr_req,
   input  logic [ADDR_W-1:0] cpu_wr_addr,
   input  logic [DATA_W-1:0] cpu_wr_data,
   output logic              cpu_wr_gnt,
   input  logic              cpu_rd_req,
   input  logic [ADDR_W-1:0] cpu_rd_addr,
   output logic              cpu_rd_gnt,
   input  logic              lcd_rd_req,
   input  logic [ADDR_W-1:0] lcd_rd_addr,
   output logic              lcd_rd_gnt,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              rd_tag,
   input  logic              boot_busy,
   output logic              cea,
   output logic [ADDR_W-1:0] ada,
   output logic [DATA_W-1:0] din,
   output logic              ceb,
   output logic [ADDR_W-1:0] adb,
   output logic              oce,
   output logic              reseta,
   output logic              resetb,
   input  logic [DATA_W-1:0] dout
);

   localparam int unsigned PIPE_D = 1 + READ_LATENCY;

   typedef enum logic {
      SRC_CPU = 1'b0,
      SRC_LCD = 1'b1
   } rd_src_e;

   logic              defer_q, defer_d;
   logic              cea_q, cea_d;
   logic [ADDR_W-1:0] ada_q, ada_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic              ceb_q, ceb_d;
   logic [ADDR_W-1:0] adb_q, adb_d;
   logic [PIPE_D-1:0] vld_q, vld_d;
   logic [PIPE_D-1:0] tag_q, tag_d;
   logic              reseta_q, resetb_q;

   logic              boot_gnt, cpu_gnt, wr_any;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              rd_any, rd_gnt, hazard;
   rd_src_e           rd_win;
   logic [ADDR_W-1:0] rd_addr;

`ifdef BSRAM_ARB_LCD_PRIO_EN
   always_comb begin
      rd_win = lcd_rd_req ? SRC_LCD : SRC_CPU;
   end
`else
   rd_src_e rr_ptr_q, rr_ptr_d;

   // rr_ptr_q names the requester that wins the next contended cycle
   always_comb begin
      if (cpu_rd_req && lcd_rd_req) begin
         rd_win = rr_ptr_q;
      end else if (lcd_rd_req) begin
         rd_win = SRC_LCD;
      end else begin
         rd_win = SRC_CPU;
      end
      rr_ptr_d = rr_ptr_q;
      if (rd_gnt && cpu_rd_req && lcd_rd_req) begin
         rr_ptr_d = (rd_win == SRC_CPU) ? SRC_LCD : SRC_CPU;
      end
   end

   always_ff @(posedge MEMORY_CLK) begin
      if (rst) begin
         rr_ptr_q <= SRC_CPU;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end
`endif

   always_comb begin
      boot_gnt = !rst && boot_wr_req && !defer_q;
      cpu_gnt  = !rst && cpu_wr_req && !boot_wr_req && !boot_busy && !defer_q;
      wr_any   = boot_gnt || cpu_gnt;
      wr_addr  = boot_gnt ? boot_wr_addr : cpu_wr_addr;
      wr_data  = boot_gnt ? boot_wr_data : cpu_wr_data;

      rd_any  = !rst && (cpu_rd_req || lcd_rd_req);
      rd_addr = (rd_win == SRC_LCD) ? lcd_rd_addr : cpu_rd_addr;
      // a read colliding with this cycle's write waits; defer_q then blocks writes
      hazard  = rd_any && wr_any && (rd_addr == wr_addr);
      rd_gnt  = rd_any && !hazard;
   end

   always_comb begin
      defer_d = hazard;
      cea_d   = wr_any;
      ada_d   = wr_any ? wr_addr : ada_q;
      din_d   = wr_any ? wr_data : din_q;
      ceb_d   = rd_gnt;
      adb_d   = rd_gnt ? rd_addr : adb_q;
      vld_d   = {vld_q[PIPE_D-2:0], rd_gnt};
      tag_d   = {tag_q[PIPE_D-2:0], rd_gnt && (rd_win == SRC_LCD)};
   end

   always_ff @(posedge MEMORY_CLK) begin
      if (rst) begin
         defer_q <= 1'b0;
         cea_q   <= 1'b0;
         ada_q   <= '0;
         din_q   <= '0;
         ceb_q   <= 1'b0;
         adb_q   <= '0;
         vld_q   <= '0;
         tag_q   <= '0;
      end else begin
         defer_q <= defer_d;
         cea_q   <= cea_d;
         ada_q   <= ada_d;
         din_q   <= din_d;
         ceb_q   <= ceb_d;
         adb_q   <= adb_d;
         vld_q   <= vld_d;
         tag_q   <= tag_d;
      end
   end

   always_ff @(posedge MEMORY_CLK) begin
      reseta_q <= rst;
      resetb_q <= rst;
   end

   assign boot_wr_gnt = boot_gnt;
   assign cpu_wr_gnt  = cpu_gnt;
   assign cpu_rd_gnt  = rd_gnt && (rd_win == SRC_CPU);
   assign lcd_rd_gnt  = rd_gnt && (rd_win == SRC_LCD);

   assign cea      = cea_q;
   assign ada      = ada_q;
   assign din      = din_q;
   assign ceb      = ceb_q;
   assign adb      = adb_q;
   assign oce      = 1'b1;
   assign reseta   = reseta_q;
   assign resetb   = resetb_q;
   assign rd_valid = vld_q[PIPE_D-1];
   assign rd_tag   = tag_q[PIPE_D-1];
   assign rd_data  = dout;

endmodule
